// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the game sequencer (game_flow_ctl) and its
// one-second prescaler (sec_tick_gen).
//   state_t          : 2-bit FSM state encoding
//   ST_IDLE/PLAY/OVER: FSM state constants
//   SCORE_W/SCORE_MAX: score counter width and saturation value
//   SEC_W            : width of the seconds and hold counters
//   sat_inc()        : saturating +1 for a score counter
// -----------------------------------------------------------------------------
package game_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PLAY = 2'd1;
  localparam state_t ST_OVER = 2'd2;

  localparam int                 SCORE_W   = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'hFF;
  localparam int                 SEC_W     = 7;

  // Scores stop at SCORE_MAX instead of wrapping back to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 8'd1;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// -----------------------------------------------------------------------------
// sec_tick_gen
// Divides pclk down to a one-cycle pulse per second of game time.
// The counter runs 0..CLK_HZ-1 while enabled; o_sec_tick is high on the
// terminal-count cycle only (and only while enabled). Disabling freezes the
// count, so a later enable resumes from where it stopped.
// Ports:
//   i_clk      : pixel clock
//   i_rst_n    : asynchronous active-low reset (count -> 0)
//   i_clr      : synchronous clear to 0, has priority over i_en
//   i_en       : count enable
//   o_sec_tick : terminal-count pulse
// -----------------------------------------------------------------------------
module sec_tick_gen #(
  parameter int CLK_HZ = 65000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sec_tick
);

  // A 1 Hz clock would give $clog2 of 0; keep at least one bit.
  localparam int               CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] TC    = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc       = (r_cnt == TC);
  assign o_sec_tick = i_en && w_tc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_flow_ctl.sv
// -----------------------------------------------------------------------------
// game_flow_ctl
// Round sequencer for the game-over overlay: IDLE -> PLAY -> OVER -> PLAY ...
// Runs a GAME_SECONDS countdown, accumulates saturating per-player scores from
// hit pulses, and holds the game-over screen for at least HOLD_SECONDS before
// a restart is accepted. All outputs are registered.
//
// Build option: define GAME_FLOW_PAUSE_EN to add the 'pause' input. While
// pause is high in PLAY the prescaler and countdown freeze, hits are dropped
// and 'playing' falls to 0; the FSM stays in PLAY.
//
// Request protocol: start/hit_p1/hit_p2 are single-cycle pulses with no
// ready/acknowledge. A pulse is acted on in the cycle it is seen if the FSM
// can accept it, otherwise it is dropped (never queued).
//
// FSM state is visible outside through time_out (OVER) and playing (PLAY);
// both low means IDLE.
//
// Ports:
//   pclk, rst_n    : pixel clock, asynchronous active-low reset
//   start          : start/restart request pulse
//   players_sel    : 0 = one player, 1 = two players (latched on start)
//   hit_p1, hit_p2 : score event pulses
//   pause          : (GAME_FLOW_PAUSE_EN only) freeze the running round
//   time_out       : 1 while in OVER
//   no_of_players  : latched players_sel
//   player1_score  : player 1 score, saturating at 255
//   player2_score  : player 2 score, saturating at 255 (two-player only)
//   seconds_left   : remaining round seconds
//   playing        : 1 while in PLAY (and not paused)
// -----------------------------------------------------------------------------
module game_flow_ctl
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 65000000,
  parameter int GAME_SECONDS = 99,
  parameter int HOLD_SECONDS = 3
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               players_sel,
  input  logic               hit_p1,
  input  logic               hit_p2,
`ifdef GAME_FLOW_PAUSE_EN
  input  logic               pause,
`endif
  output logic               time_out,
  output logic               no_of_players,
  output logic [SCORE_W-1:0] player1_score,
  output logic [SCORE_W-1:0] player2_score,
  output logic [SEC_W-1:0]   seconds_left,
  output logic               playing
);

  localparam logic [SEC_W-1:0] GAME_SEC = SEC_W'(GAME_SECONDS);
  localparam logic [SEC_W-1:0] HOLD_SEC = SEC_W'(HOLD_SECONDS);

  state_t             r_state;
  logic               r_time_out;
  logic               r_playing;
  logic               r_no_of_players;
  logic [SCORE_W-1:0] r_p1_score;
  logic [SCORE_W-1:0] r_p2_score;
  logic [SEC_W-1:0]   r_seconds_left;
  logic [SEC_W-1:0]   r_hold_cnt;

  logic w_paused;
  logic w_run;
  logic w_hold_done;
  logic w_start_ok;
  logic w_tick_en;
  logic w_sec_tick;

`ifdef GAME_FLOW_PAUSE_EN
  assign w_paused = pause;
`else
  assign w_paused = 1'b0;
`endif

  // w_run: the round is actually advancing this cycle.
  assign w_run       = (r_state == ST_PLAY) && !w_paused;
  assign w_hold_done = (r_hold_cnt == HOLD_SEC);
  // A restart out of OVER is only honoured once the hold time has elapsed.
  assign w_start_ok  = start && ((r_state == ST_IDLE) ||
                                 ((r_state == ST_OVER) && w_hold_done));
  // One prescaler serves both the countdown (PLAY) and the hold timer (OVER).
  assign w_tick_en   = w_run || ((r_state == ST_OVER) && !w_hold_done);

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick_gen (
    .i_clk      (pclk),
    .i_rst_n    (rst_n),
    .i_clr      (w_start_ok),
    .i_en       (w_tick_en),
    .o_sec_tick (w_sec_tick)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_time_out      <= 1'b0;
      r_playing       <= 1'b0;
      r_no_of_players <= 1'b0;
      r_p1_score      <= '0;
      r_p2_score      <= '0;
      r_seconds_left  <= GAME_SEC;
      r_hold_cnt      <= '0;
    end else if (w_start_ok) begin
      // Same action from IDLE and from an expired OVER.
      r_state         <= ST_PLAY;
      r_time_out      <= 1'b0;
      r_playing       <= 1'b1;
      r_no_of_players <= players_sel;
      r_p1_score      <= '0;
      r_p2_score      <= '0;
      r_seconds_left  <= GAME_SEC;
      r_hold_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end

        ST_PLAY: begin
          r_playing <= !w_paused;
          if (w_run) begin
            // Hits still count on the final-tick cycle.
            if (hit_p1) begin
              r_p1_score <= sat_inc(r_p1_score);
            end
            if (hit_p2 && r_no_of_players) begin
              r_p2_score <= sat_inc(r_p2_score);
            end
            if (w_sec_tick) begin
              if (r_seconds_left <= 7'd1) begin
                r_seconds_left <= '0;
                r_state        <= ST_OVER;
                r_time_out     <= 1'b1;
                r_playing      <= 1'b0;
                r_hold_cnt     <= '0;
              end else begin
                r_seconds_left <= r_seconds_left - 7'd1;
              end
            end
          end
        end

        ST_OVER: begin
          if (w_sec_tick && !w_hold_done) begin
            r_hold_cnt <= r_hold_cnt + 7'd1;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_time_out <= 1'b0;
          r_playing  <= 1'b0;
        end
      endcase
    end
  end

  assign time_out      = r_time_out;
  assign playing       = r_playing;
  assign no_of_players = r_no_of_players;
  assign player1_score = r_p1_score;
  assign player2_score = r_p2_score;
  assign seconds_left  = r_seconds_left;

endmodule

// File: tb/tb_game_flow_ctl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctl
// Self-checking bench for game_flow_ctl with CLK_HZ=10, GAME_SECONDS=3,
// HOLD_SECONDS=2 (u_dut) plus a long-round instance (GAME_SECONDS=127,
// u_dut_long) for score saturation. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_game_flow_ctl;

  // ---------------------------------------------------------------- clock/reset
  logic pclk;
  logic rst_n;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------------------------------------------------------- DUT signals
  logic       start, players_sel, hit_p1, hit_p2;
  logic       time_out, no_of_players, playing;
  logic [7:0] player1_score, player2_score;
  logic [6:0] seconds_left;

  logic       l_start, l_players_sel, l_hit_p1, l_hit_p2;
  logic       l_time_out, l_no_of_players, l_playing;
  logic [7:0] l_player1_score, l_player2_score;
  logic [6:0] l_seconds_left;

`ifdef GAME_FLOW_PAUSE_EN
  logic pause;
  initial pause = 1'b0;
`endif

  game_flow_ctl #(
    .CLK_HZ       (10),
    .GAME_SECONDS (3),
    .HOLD_SECONDS (2)
  ) u_dut (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .start         (start),
    .players_sel   (players_sel),
    .hit_p1        (hit_p1),
    .hit_p2        (hit_p2),
`ifdef GAME_FLOW_PAUSE_EN
    .pause         (pause),
`endif
    .time_out      (time_out),
    .no_of_players (no_of_players),
    .player1_score (player1_score),
    .player2_score (player2_score),
    .seconds_left  (seconds_left),
    .playing       (playing)
  );

  game_flow_ctl #(
    .CLK_HZ       (10),
    .GAME_SECONDS (127),
    .HOLD_SECONDS (2)
  ) u_dut_long (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .start         (l_start),
    .players_sel   (l_players_sel),
    .hit_p1        (l_hit_p1),
    .hit_p2        (l_hit_p2),
`ifdef GAME_FLOW_PAUSE_EN
    .pause         (pause),
`endif
    .time_out      (l_time_out),
    .no_of_players (l_no_of_players),
    .player1_score (l_player1_score),
    .player2_score (l_player2_score),
    .seconds_left  (l_seconds_left),
    .playing       (l_playing)
  );

  // Output snapshot: {time_out, playing, no_of_players, p1, p2, seconds_left}
  logic [25:0] w_obs, w_lobs;
  assign w_obs  = {time_out, playing, no_of_players,
                   player1_score, player2_score, seconds_left};
  assign w_lobs = {l_time_out, l_playing, l_no_of_players,
                   l_player1_score, l_player2_score, l_seconds_left};

  // ---------------------------------------------------------------- scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [25:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] pack(input logic to, input logic pl,
                                       input logic np, input logic [7:0] p1,
                                       input logic [7:0] p2,
                                       input logic [6:0] sl);
    return {to, pl, np, p1, p2, sl};
  endfunction

  task automatic expect_out(input string tag, input logic [25:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sb_check(input logic [25:0] obs);
    logic [25:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".time_out"},      32'(obs[25]),    32'(e[25]));
    check({t, ".playing"},       32'(obs[24]),    32'(e[24]));
    check({t, ".no_of_players"}, 32'(obs[23]),    32'(e[23]));
    check({t, ".p1_score"},      32'(obs[22:15]), 32'(e[22:15]));
    check({t, ".p2_score"},      32'(obs[14:7]),  32'(e[14:7]));
    check({t, ".seconds_left"},  32'(obs[6:0]),   32'(e[6:0]));
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  logic [25:0] idle_v;
  logic [25:0] over_v;

  initial begin
    rst_n = 1'b0; start = 1'b0; players_sel = 1'b0; hit_p1 = 1'b0; hit_p2 = 1'b0;
    l_start = 1'b0; l_players_sel = 1'b0; l_hit_p1 = 1'b0; l_hit_p2 = 1'b0;
    idle_v = pack(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 7'd3);
    over_v = pack(1'b1, 1'b0, 1'b1, 8'd4, 8'd3, 7'd0);

    step(2);
    expect_out("reset", idle_v);
    sb_check(w_obs);
    rst_n = 1'b1;
    step(2);
    expect_out("idle", idle_v);
    sb_check(w_obs);

    // Hits in IDLE are ignored.
    hit_p1 = 1'b1; hit_p2 = 1'b1;
    expect_out("idle_hit", idle_v);
    step(1);
    hit_p1 = 1'b0; hit_p2 = 1'b0;
    sb_check(w_obs);

    // Two-player round; sample point is now PLAY cycle 1.
    start = 1'b1; players_sel = 1'b1;
    expect_out("start_2p", pack(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 7'd3));
    step(1);
    start = 1'b0; players_sel = 1'b0;
    sb_check(w_obs);

    // Three simultaneous hits (cycles 1..3).
    hit_p1 = 1'b1; hit_p2 = 1'b1;
    step(3);
    hit_p1 = 1'b0; hit_p2 = 1'b0;
    expect_out("both_hits", pack(1'b0, 1'b1, 1'b1, 8'd3, 8'd3, 7'd3));
    sb_check(w_obs);

    step(6);   // cycle 10: tick cycle, not yet applied
    expect_out("pre_tick1", pack(1'b0, 1'b1, 1'b1, 8'd3, 8'd3, 7'd3));
    sb_check(w_obs);
    step(1);   // cycle 11
    expect_out("tick1", pack(1'b0, 1'b1, 1'b1, 8'd3, 8'd3, 7'd2));
    sb_check(w_obs);
    step(10);  // cycle 21
    expect_out("tick2", pack(1'b0, 1'b1, 1'b1, 8'd3, 8'd3, 7'd1));
    sb_check(w_obs);
    step(9);   // cycle 30: final tick cycle
    expect_out("last_play", pack(1'b0, 1'b1, 1'b1, 8'd3, 8'd3, 7'd1));
    sb_check(w_obs);

    // Hit on the final-tick cycle counts.
    hit_p1 = 1'b1;
    expect_out("over_entry", over_v);
    step(1);   // OVER cycle 1, hit_p1 still high: ignored
    sb_check(w_obs);
    expect_out("over_hit", over_v);
    step(1);   // OVER cycle 2
    hit_p1 = 1'b0;
    sb_check(w_obs);

    // Start during hold is dropped.
    step(3);   // OVER cycle 5
    start = 1'b1;
    expect_out("early_start", over_v);
    step(1);
    start = 1'b0;
    sb_check(w_obs);
    step(14);  // OVER cycle 20: last cycle before hold expiry
    start = 1'b1;
    expect_out("hold_edge", over_v);
    step(1);   // OVER cycle 21
    start = 1'b0;
    sb_check(w_obs);

    // Start after hold expiry: restart as a one-player round.
    start = 1'b1; players_sel = 1'b0;
    expect_out("restart_1p", pack(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 7'd3));
    step(1);
    start = 1'b0;
    sb_check(w_obs);

    // One player: 5x hit_p1, 4x hit_p2 (p2 ignored).
    hit_p1 = 1'b1; hit_p2 = 1'b1;
    step(4);
    hit_p2 = 1'b0;
    step(1);
    hit_p1 = 1'b0;
    expect_out("one_player", pack(1'b0, 1'b1, 1'b0, 8'd5, 8'd0, 7'd3));
    sb_check(w_obs);

    hit_p1 = 1'b1;
    step(2);   // cycle 8, score 7
    hit_p1 = 1'b0;
    step(3);   // cycle 11
    expect_out("pre_reset", pack(1'b0, 1'b1, 1'b0, 8'd7, 8'd0, 7'd2));
    sb_check(w_obs);

    // Asynchronous abort, checked before the next clock edge.
    rst_n = 1'b0; hit_p1 = 1'b1;
    #2;
    expect_out("async_reset", idle_v);
    sb_check(w_obs);
    step(2);
    rst_n = 1'b1; hit_p1 = 1'b0;
    step(1);
    expect_out("after_reset", idle_v);
    sb_check(w_obs);

    start = 1'b1; players_sel = 1'b1;
    expect_out("restart_after_reset", pack(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 7'd3));
    step(1);
    start = 1'b0; players_sel = 1'b0;
    sb_check(w_obs);
    hit_p1 = 1'b1;
    expect_out("hit_after_reset", pack(1'b0, 1'b1, 1'b1, 8'd1, 8'd0, 7'd3));
    step(1);
    hit_p1 = 1'b0;
    sb_check(w_obs);

    // Long round: 3 simultaneous hits then 300 hit_p1 -> p1 saturates.
    l_start = 1'b1; l_players_sel = 1'b1;
    expect_out("long_start", pack(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 7'd127));
    step(1);
    l_start = 1'b0; l_players_sel = 1'b0;
    sb_check(w_lobs);
    l_hit_p1 = 1'b1; l_hit_p2 = 1'b1;
    step(3);
    l_hit_p2 = 1'b0;
    step(300); // sample at cycle 304, 30 ticks elapsed
    l_hit_p1 = 1'b0;
    expect_out("saturate", pack(1'b0, 1'b1, 1'b1, 8'd255, 8'd3, 7'd97));
    sb_check(w_lobs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
